// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-read-port register file.
package regfile_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'(1) << addr_w;
  endfunction

  localparam int unsigned DEPTH_DEF = depth_of(ADDR_W_DEF);

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks every entry writing zero after reset or on request,
// then hands the write port over to normal operation.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  output logic              o_clr_we_c,
  output logic [ADDR_W-1:0] o_clr_addr_c,
  output logic              o_run_c,
  output logic              o_busy
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;

  // Counter wraps to zero on the same edge that leaves CLEAR.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == {ADDR_W{1'b1}}) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (i_clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == ST_CLEAR);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign o_clr_we_c   = (state_q == ST_CLEAR);
  assign o_clr_addr_c = cnt_q;
  assign o_run_c      = (state_q == ST_RUN);
  assign o_busy       = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-first bypass, optional hardwired
// zero entry and a sequenced clear so the array needs no per-entry reset.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clr,
  input  logic [NREAD-1:0]        i_re,
  input  logic [NREAD*ADDR_W-1:0] i_raddr,
  input  logic                    i_we,
  input  logic [ADDR_W-1:0]       i_waddr,
  input  logic [DATA_W-1:0]       i_wdata,
  output logic [NREAD*DATA_W-1:0] o_rdata,
  output logic                    o_busy
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  logic              clr_we_c;
  logic [ADDR_W-1:0] clr_addr_c;
  logic              run_c;

  regfile_clr_seq #(
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_clr        (i_clr),
    .o_clr_we_c   (clr_we_c),
    .o_clr_addr_c (clr_addr_c),
    .o_run_c      (run_c),
    .o_busy       (o_busy)
  );

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_waddr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic              wr_ok_c;

  // A pending clear request outranks a same-edge external write.
  always_comb begin
    wr_ok_c     = run_c && i_we && !i_clr && !((ZERO_REG != 0) && (i_waddr == '0));
    mem_we_c    = 1'b0;
    mem_waddr_c = clr_addr_c;
    mem_wdata_c = '0;
    if (clr_we_c) begin
      mem_we_c = 1'b1;
    end else if (wr_ok_c) begin
      mem_we_c    = 1'b1;
      mem_waddr_c = i_waddr;
      mem_wdata_c = i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we_c) mem_q[mem_waddr_c] <= mem_wdata_c;
  end

  logic [ADDR_W-1:0] raddr_c [NREAD];
  logic [DATA_W-1:0] rdata_q [NREAD];
  logic [DATA_W-1:0] rdata_d [NREAD];

  for (genvar g = 0; g < NREAD; g++) begin : g_port
    assign raddr_c[g]                  = i_raddr[g*ADDR_W +: ADDR_W];
    assign o_rdata[g*DATA_W +: DATA_W] = rdata_q[g];
  end

  // Outputs read zero for the whole clear window, including the request edge.
  always_comb begin
    for (int k = 0; k < NREAD; k++) begin
      rdata_d[k] = rdata_q[k];
      if (!run_c || i_clr) begin
        rdata_d[k] = '0;
      end else if (i_re[k]) begin
        if ((ZERO_REG != 0) && (raddr_c[k] == '0)) begin
          rdata_d[k] = '0;
        end else if (wr_ok_c && (raddr_c[k] == i_waddr)) begin
          rdata_d[k] = i_wdata;
        end else begin
          rdata_d[k] = mem_q[raddr_c[k]];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NREAD; k++) rdata_q[k] <= '0;
    end else begin
      for (int k = 0; k < NREAD; k++) rdata_q[k] <= rdata_d[k];
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: driver pushes per-edge expectations from an
// array-level reference model, a monitor pops and compares after each edge.
module tb_regfile_mp;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_clr = 1'b0;
  logic [1:0]  i_re = '0;
  logic [9:0]  i_raddr = '0;
  logic        i_we = 1'b0;
  logic [4:0]  i_waddr = '0;
  logic [31:0] i_wdata = '0;
  logic [63:0] o_rdata;
  logic        o_busy;

  always #5 i_clk = ~i_clk;

  regfile_mp #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .NREAD    (2),
    .ZERO_REG (1)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_clr),
    .i_re    (i_re),
    .i_raddr (i_raddr),
    .i_we    (i_we),
    .i_waddr (i_waddr),
    .i_wdata (i_wdata),
    .o_rdata (o_rdata),
    .o_busy  (o_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: whole-array view, clear modelled as a countdown.
  logic [31:0] m_mem [32];
  logic [31:0] m_rd [2];
  int          busy_left = 32;
  logic [64:0] exp_q [$];

  task automatic step(input logic rst, input logic clr, input logic [1:0] re,
                      input logic [4:0] ra0, input logic [4:0] ra1, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd);
    logic [4:0] ra [2];
    ra[0] = ra0;
    ra[1] = ra1;
    i_rst_n = rst; i_clr = clr; i_re = re; i_raddr = {ra1, ra0};
    i_we = we; i_waddr = wa; i_wdata = wd;
    if (!rst) begin
      busy_left = 32;
      m_rd[0] = 0; m_rd[1] = 0;
    end else if (busy_left > 0) begin
      busy_left--;
      foreach (m_mem[i]) m_mem[i] = 0;
      m_rd[0] = 0; m_rd[1] = 0;
    end else if (clr) begin
      busy_left = 32;
      foreach (m_mem[i]) m_mem[i] = 0;
      m_rd[0] = 0; m_rd[1] = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (re[k]) begin
          if (ra[k] == 0)                 m_rd[k] = 0;
          else if (we && ra[k] == wa)     m_rd[k] = wd;
          else                            m_rd[k] = m_mem[ra[k]];
        end
      end
      if (we && wa != 0) m_mem[wa] = wd;
    end
    exp_q.push_back({(busy_left > 0 || !rst), m_rd[1], m_rd[0]});
    @(negedge i_clk);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 1'b1, a, d);
  endtask

  task automatic rd2(input logic [4:0] a0, input logic [4:0] a1);
    step(1'b1, 1'b0, 2'b11, a0, a1, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic junk(input logic rst);
    step(rst, 1'($urandom), 2'($urandom), 5'($urandom), 5'($urandom),
         1'($urandom), 5'($urandom), $urandom);
  endtask

  task automatic async_rst_check();
    i_rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(o_busy), 32'd1);
    check("async_rst_rd0", o_rdata[31:0], 32'h0);
    check("async_rst_rd1", o_rdata[63:32], 32'h0);
  endtask

  logic [64:0] mon_e;
  always @(posedge i_clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("busy", 32'(o_busy), 32'(mon_e[64]));
      check("rdata0", o_rdata[31:0], mon_e[31:0]);
      check("rdata1", o_rdata[63:32], mon_e[63:32]);
    end
  end

  initial begin
    foreach (m_mem[i]) m_mem[i] = 0;
    m_rd[0] = 0; m_rd[1] = 0;
    @(negedge i_clk);
    check("reset_busy", 32'(o_busy), 32'd1);
    check("reset_rdata", o_rdata[31:0] | o_rdata[63:32], 32'h0);

    // Reset 3 cycles, then full clear with ignored garbage on the inputs
    repeat (3) junk(1'b0);
    repeat (32) junk(1'b1);
    for (int i = 0; i < 16; i++) rd2(5'(2*i), 5'(2*i+1));
    idle();

    // Basic write then dual read of the same entry
    wr(5'd5, 32'hDEADBEEF);
    rd2(5'd5, 5'd5);
    idle();

    // Same-edge bypass on port 1, port 0 holds
    wr(5'd9, 32'hDEADBEEF);
    rd2(5'd9, 5'd9);
    step(1'b1, 1'b0, 2'b10, 5'd0, 5'd9, 1'b1, 5'd9, 32'h12345678);
    idle();

    // Zero register ignores writes and bypass
    step(1'b1, 1'b0, 2'b11, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
    rd2(5'd0, 5'd0);

    // Clear request wins over a same-edge write; writes during clear dropped
    wr(5'd3, 32'hA5A5A5A5);
    rd2(5'd3, 5'd3);
    step(1'b1, 1'b1, 2'b00, 5'd0, 5'd0, 1'b1, 5'd4, 32'h11);
    for (int i = 0; i < 32; i++)
      step(1'b1, 1'($urandom), 2'b11, 5'd3, 5'd4, 1'b1, 5'(3 + (i % 2)), $urandom);
    rd2(5'd3, 5'd4);
    idle();

    // Async reset mid-run with live data, then mid-clear at cycle 10
    wr(5'd7, 32'hCAFEF00D);
    rd2(5'd7, 5'd7);
    async_rst_check();
    repeat (2) junk(1'b0);
    repeat (10) junk(1'b1);
    async_rst_check();
    repeat (2) junk(1'b0);
    repeat (32) junk(1'b1);
    idle();

    // Randomized traffic over a small address window to provoke bypass hits
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 299) != 0), 1'($urandom_range(0, 63) == 0),
           2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom), 5'($urandom_range(0, 7)), $urandom);
    end
    idle();

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge i_clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
